// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the SRAM device adapter and its bench.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_DUW = 4;
  localparam int unsigned TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Opcode fields are plain vectors so illegal encodings can be carried and rejected.
  typedef struct packed {
    logic                  a_valid;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DW/8-1:0]    a_mask;
    logic [TL_DW-1:0]      a_data;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    logic [2:0]            d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic [TL_DUW-1:0]     d_user;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_device_adapter.sv
// TL-UL device adapter driving a single-port SRAM with 1-cycle read latency.
// Requests are checked, issued to the SRAM, and their responses queued in a small
// circular FIFO so the host can keep up to Depth requests outstanding.
module tlul_sram_device_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned SramAw = 12,
  parameter int unsigned Depth  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wmask_o,
  input  logic [31:0]       rdata_i
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic              err;
  } meta_t;

  typedef struct packed {
    meta_t       meta;
    logic [31:0] data;
  } rsp_t;

  meta_t            meta_q, meta_d;
  logic             inflight_q, inflight_d;
  logic             a_ready_q, a_ready_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  rsp_t             fifo_q [Depth];
  rsp_t             fifo_d [Depth];

  logic is_put, op_ok, align_ok, a_err, accept;
  logic push, pop, empty, full;
  rsp_t push_entry, head;

  // Bits that the xbar has already decoded, or that carry nothing for this device.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:SramAw+2]};

  // Request legality check and SRAM strobe generation for the accepting cycle.
  always_comb begin
    is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    op_ok  = is_put || (tl_i.a_opcode == Get);
    case (tl_i.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~tl_i.a_address[0];
      2'd2:    align_ok = (tl_i.a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    a_err   = ~(op_ok & align_ok);
    accept  = tl_i.a_valid & a_ready_q;
    req_o   = accept & ~a_err;
    we_o    = req_o & is_put;
    addr_o  = tl_i.a_address[SramAw+1:2];
    wdata_o = tl_i.a_data;
    wmask_o = tl_i.a_mask;
  end

  // Next-state for the in-flight stage, response FIFO and registered a_ready.
  always_comb begin
    meta_d     = meta_q;
    inflight_d = accept;
    if (accept) begin
      meta_d.opcode = tl_i.a_opcode;
      meta_d.size   = tl_i.a_size;
      meta_d.source = tl_i.a_source;
      meta_d.err    = a_err;
    end

    empty = (count_q == '0);
    full  = (count_q == CntW'(Depth));
    push  = inflight_q;
    pop   = ~empty & tl_i.d_ready;

    // Anything that is not a Put answers with data; errors force all-ones.
    push_entry.meta = meta_q;
    if ((meta_q.opcode == PutFullData) || (meta_q.opcode == PutPartialData)) begin
      push_entry.data = 32'h0;
    end else if (meta_q.err) begin
      push_entry.data = 32'hFFFF_FFFF;
    end else begin
      push_entry.data = rdata_i;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Registering the sum keeps a_ready free of any path from d_ready or a_valid.
    a_ready_d = (int'(count_d) + int'(inflight_d)) < int'(Depth);
  end

  // State registers with synchronous reset; reset drops everything outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q     <= '0;
      inflight_q <= 1'b0;
      a_ready_q  <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      meta_q     <= meta_d;
      inflight_q <= inflight_d;
      a_ready_q  <= a_ready_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  // D channel presents the FIFO head; all fields idle at zero while empty.
  always_comb begin
    head         = fifo_q[rd_ptr_q];
    tl_o         = '0;
    tl_o.a_ready = a_ready_q;
    if (!empty) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = ((head.meta.opcode == PutFullData) ||
                       (head.meta.opcode == PutPartialData)) ? AccessAck : AccessAckData;
      tl_o.d_size   = head.meta.size;
      tl_o.d_source = head.meta.source;
      tl_o.d_data   = head.data;
      tl_o.d_error  = head.meta.err;
    end
  end

  // The a_ready accounting must make a push into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_tlul_sram_device_adapter.sv
// Self-checking bench: table of TL-UL requests with expected responses, a scoreboard
// queue popped by a D-channel monitor, and hand-written backpressure/reset sequences.
module tb_tlul_sram_device_adapter;
  import tlul_pkg::*;

  localparam int unsigned SramAw = 12;
  localparam int unsigned Depth  = 2;

  logic              clk = 1'b0;
  logic              reset;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              req_o, we_o;
  logic [SramAw-1:0] addr_o;
  logic [31:0]       wdata_o, rdata_i;
  logic [3:0]        wmask_o;

  always #5 clk = ~clk;

  tlul_sram_device_adapter #(.SramAw(SramAw), .Depth(Depth)) dut (
    .clock   (clk),
    .reset   (reset),
    .tl_i    (tl_i),
    .tl_o    (tl_o),
    .req_o   (req_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .wmask_o (wmask_o),
    .rdata_i (rdata_i)
  );

  // SRAM environment model: byte-masked write, registered read.
  logic [31:0] sram [1 << SramAw];
  always @(posedge clk) begin
    if (req_o) begin
      if (we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_o[b]) sram[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
        end
      end else begin
        rdata_i <= sram[addr_o];
      end
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [7:0]  src;
    logic        exp_err;
    logic [2:0]  exp_dop;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [7:0]  src;
    logic [2:0]  dop;
    logic [1:0]  size;
    logic        err;
    logic [31:0] data;
  } exp_rsp_t;

  int errors = 0;
  int checks = 0;
  int rsp_seen = 0;
  exp_rsp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] op, input logic [1:0] sz,
                              input logic [31:0] ad, input logic [31:0] dt,
                              input logic [3:0] m, input logic [7:0] src, input logic er,
                              input logic [2:0] dop, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.op = op; v.size = sz; v.addr = ad; v.data = dt; v.mask = m; v.src = src;
    v.exp_err = er; v.exp_dop = dop; v.exp_data = ed;
    return v;
  endfunction

  // D-channel monitor: every handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (!reset && tl_o.d_valid && tl_i.d_ready) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got source %h data %h with nothing outstanding",
                 tl_o.d_source, tl_o.d_data);
      end else begin
        exp_rsp_t e;
        e = sb.pop_front();
        check($sformatf("rsp_src%0h", e.src),
              64'({tl_o.d_param, tl_o.d_sink, tl_o.d_user, tl_o.d_source, tl_o.d_opcode,
                   tl_o.d_size, tl_o.d_error, tl_o.d_data}),
              64'({8'h0, e}));
      end
    end
  end

  task automatic drive_a(input vec_t v);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = v.op;
    tl_i.a_param   = '0;
    tl_i.a_size    = v.size;
    tl_i.a_source  = v.src;
    tl_i.a_address = v.addr;
    tl_i.a_mask    = v.mask;
    tl_i.a_data    = v.data;
  endtask

  // Waits (bounded) for a_ready at a negedge, checks SRAM strobes, records expectation.
  task automatic accept_check(input vec_t v);
    int n = 0;
    logic exp_we;
    #1;
    while (!tl_o.a_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({v.name, "_a_ready"}, 64'(tl_o.a_ready), 64'(1));
    exp_we = ((v.op == 3'd0) || (v.op == 3'd1)) && !v.exp_err;
    check({v.name, "_req"}, 64'(req_o), 64'(!v.exp_err));
    if (!v.exp_err) begin
      check({v.name, "_sram"}, 64'({we_o, addr_o, wmask_o, wdata_o}),
            64'({exp_we, v.addr[SramAw+1:2], v.mask, v.data}));
    end
    sb.push_back('{src: v.src, dop: v.exp_dop, size: v.size, err: v.exp_err,
                   data: v.exp_data});
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    drive_a(v);
    accept_check(v);
  endtask

  task automatic idle();
    @(negedge clk);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic set_dready(input logic r);
    @(posedge clk);
    #2;
    tl_i.d_ready = r;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tl_d2h_t snap;
    int seen0;
    tl_i  = '0;
    reset = 1'b1;

    vecs[0]  = mk("put_full",   3'd0, 2'd2, 32'h10,       32'hDEAD_BEEF, 4'hF, 8'h01, 1'b0, 3'd0, 32'h0);
    vecs[1]  = mk("get_full",   3'd4, 2'd2, 32'h10,       32'h0,         4'hF, 8'h02, 1'b0, 3'd1, 32'hDEAD_BEEF);
    vecs[2]  = mk("put_base",   3'd0, 2'd2, 32'h20,       32'h1122_3344, 4'hF, 8'h03, 1'b0, 3'd0, 32'h0);
    vecs[3]  = mk("put_part",   3'd1, 2'd2, 32'h20,       32'h0000_AB00, 4'h2, 8'h04, 1'b0, 3'd0, 32'h0);
    vecs[4]  = mk("get_part",   3'd4, 2'd2, 32'h20,       32'h0,         4'hF, 8'h05, 1'b0, 3'd1, 32'h1122_AB44);
    vecs[5]  = mk("bad_op",     3'd3, 2'd2, 32'h10,       32'h0,         4'hF, 8'h06, 1'b1, 3'd1, 32'hFFFF_FFFF);
    vecs[6]  = mk("misalign_w", 3'd4, 2'd2, 32'h6,        32'h0,         4'hF, 8'h07, 1'b1, 3'd1, 32'hFFFF_FFFF);
    vecs[7]  = mk("get_half",   3'd4, 2'd1, 32'h12,       32'h0,         4'hF, 8'h08, 1'b0, 3'd1, 32'hDEAD_BEEF);
    vecs[8]  = mk("misalign_h", 3'd4, 2'd1, 32'h11,       32'h0,         4'hF, 8'h09, 1'b1, 3'd1, 32'hFFFF_FFFF);
    vecs[9]  = mk("put_byte",   3'd1, 2'd0, 32'h23,       32'h5500_0000, 4'h8, 8'h0A, 1'b0, 3'd0, 32'h0);
    vecs[10] = mk("bad_size",   3'd4, 2'd3, 32'h20,       32'h0,         4'hF, 8'h0B, 1'b1, 3'd1, 32'hFFFF_FFFF);
    vecs[11] = mk("get_merge",  3'd4, 2'd2, 32'h20,       32'h0,         4'hF, 8'h0C, 1'b0, 3'd1, 32'h5522_AB44);
    vecs[12] = mk("put_err",    3'd0, 2'd2, 32'h22,       32'h1234_5678, 4'hF, 8'h0D, 1'b1, 3'd0, 32'h0);
    vecs[13] = mk("addr_hi",    3'd4, 2'd2, 32'hFFFF_C010, 32'h0,        4'hF, 8'h0E, 1'b0, 3'd1, 32'hDEAD_BEEF);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_we", 64'({req_o, we_o}), 64'(0));
    check("reset_tl_o", 64'(tl_o), 64'(0));
    reset = 1'b0;

    // Table of single requests, responses drained continuously.
    set_dready(1'b1);
    foreach (vecs[i]) send(vecs[i]);
    idle();
    drain("table");

    // Minimum latency: accepted at edge P0, visible after P1.
    send(mk("lat", 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h20, 1'b0, 3'd1, 32'hDEAD_BEEF));
    idle();
    check("lat_after_accept", 64'(tl_o.d_valid), 64'(0));
    @(negedge clk);
    check("lat_two_cycles", 64'(tl_o.d_valid), 64'(1));
    drain("lat");

    // Backpressure: two accepted, third stalls until the first pop.
    set_dready(1'b0);
    send(mk("bp_a", 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h30, 1'b0, 3'd1, 32'hDEAD_BEEF));
    send(mk("bp_b", 3'd4, 2'd2, 32'h20, 32'h0, 4'hF, 8'h31, 1'b0, 3'd1, 32'h5522_AB44));
    @(negedge clk);
    drive_a(mk("bp_c", 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h32, 1'b0, 3'd1, 32'hDEAD_BEEF));
    #1;
    check("bp_third_stalled", 64'(tl_o.a_ready), 64'(0));
    check("bp_head_valid", 64'({tl_o.d_valid, tl_o.d_source}), 64'({1'b1, 8'h30}));
    snap = tl_o;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_stable", 64'(tl_o), 64'(snap));
    end
    set_dready(1'b1);
    accept_check(mk("bp_c", 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h32, 1'b0, 3'd1, 32'hDEAD_BEEF));
    idle();
    drain("bp");

    // Continuous Gets, sources 0..7 must come back in order.
    seen0 = rsp_seen;
    for (int i = 0; i < 8; i++) begin
      send(mk($sformatf("stream%0d", i), 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'(i), 1'b0, 3'd1,
              32'hDEAD_BEEF));
    end
    idle();
    drain("stream");
    check("stream_count", 64'(rsp_seen - seen0), 64'(8));

    // Reset with one response queued and one in flight: nothing may emerge afterwards.
    set_dready(1'b0);
    send(mk("rst_a", 3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h40, 1'b0, 3'd1, 32'hDEAD_BEEF));
    send(mk("rst_b", 3'd4, 2'd2, 32'h20, 32'h0, 4'hF, 8'h41, 1'b0, 3'd1, 32'h5522_AB44));
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_dvalid_aready", 64'({tl_o.d_valid, tl_o.a_ready}), 64'(0));
    sb.delete();
    reset = 1'b0;
    seen0 = rsp_seen;
    set_dready(1'b1);
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 64'(tl_o.d_valid), 64'(0));
    end
    check("rst_ready_back", 64'(tl_o.a_ready), 64'(1));
    check("rst_no_rsp", 64'(rsp_seen - seen0), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
